fp_wb_arbiter: RTL and testbench

- Writeback arbiter for the floating-point register file in the superscalar out-of-order core.
- Collects results from 4 FP requesters and grants up to 2 per cycle to the register file's two write ports:
  - req 0: FP add
  - req 1: FP mul
  - req 2: FP div
  - req 3: FP load
- Round-robin fairness; never issues two same-cycle writes to one register; register-0 writes are absorbed without using a port.

---
 rtl/fp_wb_arbiter_if.sv | 58 +++++
 rtl/fp_wb_arbiter.sv | 167 ++++++++++++++++
 tb/tb_fp_wb_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// fp_wb_arbiter_if
// Bundle between the four FP result producers, the writeback arbiter and the
// FP register file's two write ports.
//
// Signals:
//   flush      squash: no grants in the current cycle
//   req_valid  per-requester result-valid (0 add, 1 mul, 2 div, 3 load)
//   req_addr   packed destination addresses, requester i at [i*AW +: AW]
//   req_data   packed results, requester i at [i*DW +: DW]
//   req_ready  per-requester consume strobe (combinational in the arbiter)
//   we1/w_addr1/w_data1, we2/w_addr2/w_data2  registered write ports
//   stall_cnt  per-requester saturating stall counters, only present when
//              FP_WB_STALL_STATS_EN is defined
//
// Modports:
//   slave   the arbiter side
//   master  the requester / register-file side
// -----------------------------------------------------------------------------
interface fp_wb_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic              flush;
  logic [3:0]        req_valid;
  logic [4*AW-1:0]   req_addr;
  logic [4*DW-1:0]   req_data;
  logic [3:0]        req_ready;
  logic              we1;
  logic [AW-1:0]     w_addr1;
  logic [DW-1:0]     w_data1;
  logic              we2;
  logic [AW-1:0]     w_addr2;
  logic [DW-1:0]     w_data2;
`ifdef FP_WB_STALL_STATS_EN
  logic [4*16-1:0]   stall_cnt;

  modport slave (
    input  flush, req_valid, req_addr, req_data,
    output req_ready, we1, w_addr1, w_data1, we2, w_addr2, w_data2, stall_cnt
  );

  modport master (
    output flush, req_valid, req_addr, req_data,
    input  req_ready, we1, w_addr1, w_data1, we2, w_addr2, w_data2, stall_cnt
  );
`else
  modport slave (
    input  flush, req_valid, req_addr, req_data,
    output req_ready, we1, w_addr1, w_data1, we2, w_addr2, w_data2
  );

  modport master (
    output flush, req_valid, req_addr, req_data,
    input  req_ready, we1, w_addr1, w_data1, we2, w_addr2, w_data2
  );
`endif
endinterface

// File: rtl/fp_wb_arbiter.sv
// -----------------------------------------------------------------------------
// fp_wb_arbiter
// Writeback arbiter for the FP register file. Four requesters (0 add, 1 mul,
// 2 div, 3 load) compete for two registered write ports. Up to two results
// are granted per cycle in round-robin order starting at rr_ptr; two writes
// in one cycle never target the same register, and results destined for
// register 0 are consumed without occupying a port.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears write ports and rr_ptr)
//   bus    fp_wb_arbiter_if.slave: flush, req_valid/addr/data in,
//          req_ready (combinational) and registered we/w_addr/w_data x2 out
//
// Optional build macro FP_WB_STALL_STATS_EN adds bus.stall_cnt: one 16-bit
// saturating counter per requester, counting cycles where the requester was
// valid, not consumed and the cycle was not flushed.
// -----------------------------------------------------------------------------
module fp_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  fp_wb_arbiter_if.slave bus
);

  // round-robin start index
  logic [1:0]    rr_ptr_r;

  // grant decode
  logic [3:0]    ready_s;
  logic          a_vld_s;
  logic [1:0]    a_idx_s;
  logic [AW-1:0] a_addr_s;
  logic          b_vld_s;
  logic [1:0]    b_idx_s;
  logic [AW-1:0] b_addr_s;
  logic [1:0]    scan_idx_s;
  logic [AW-1:0] scan_addr_s;
  logic [DW-1:0] a_data_s;
  logic [DW-1:0] b_data_s;

  // registered write ports
  logic          we1_r;
  logic [AW-1:0] w_addr1_r;
  logic [DW-1:0] w_data1_r;
  logic          we2_r;
  logic [AW-1:0] w_addr2_r;
  logic [DW-1:0] w_data2_r;

  // Grant selection: scan from rr_ptr, absorb addr-0 results, fill slot A then
  // slot B (B must differ in address from A). Data is never looked at here so
  // req_ready stays independent of req_data.
  always_comb begin
    ready_s     = 4'b0000;
    a_vld_s     = 1'b0;
    a_idx_s     = 2'd0;
    a_addr_s    = {AW{1'b0}};
    b_vld_s     = 1'b0;
    b_idx_s     = 2'd0;
    b_addr_s    = {AW{1'b0}};
    scan_idx_s  = 2'd0;
    scan_addr_s = {AW{1'b0}};
    for (int k = 0; k < 4; k++) begin
      scan_idx_s  = rr_ptr_r + k[1:0];
      scan_addr_s = bus.req_addr[scan_idx_s*AW +: AW];
      if (bus.flush) begin
        ready_s[scan_idx_s] = 1'b0;
      end else if (!bus.req_valid[scan_idx_s]) begin
        ready_s[scan_idx_s] = 1'b0;
      end else if (scan_addr_s == {AW{1'b0}}) begin
        // register 0 is hardwired; consume without a port
        ready_s[scan_idx_s] = 1'b1;
      end else if (!a_vld_s) begin
        a_vld_s             = 1'b1;
        a_idx_s             = scan_idx_s;
        a_addr_s            = scan_addr_s;
        ready_s[scan_idx_s] = 1'b1;
      end else if (!b_vld_s && (scan_addr_s != a_addr_s)) begin
        b_vld_s             = 1'b1;
        b_idx_s             = scan_idx_s;
        b_addr_s            = scan_addr_s;
        ready_s[scan_idx_s] = 1'b1;
      end else begin
        // out of ports, or same register as slot A: wait, keep ordering
        ready_s[scan_idx_s] = 1'b0;
      end
    end
  end

  assign a_data_s      = bus.req_data[a_idx_s*DW +: DW];
  assign b_data_s      = bus.req_data[b_idx_s*DW +: DW];
  assign bus.req_ready = ready_s;

  // Write-port registers and round-robin pointer; address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we1_r     <= 1'b0;
      w_addr1_r <= {AW{1'b0}};
      w_data1_r <= {DW{1'b0}};
      we2_r     <= 1'b0;
      w_addr2_r <= {AW{1'b0}};
      w_data2_r <= {DW{1'b0}};
      rr_ptr_r  <= 2'd0;
    end else begin
      we1_r <= a_vld_s;
      we2_r <= b_vld_s;
      if (a_vld_s) begin
        w_addr1_r <= a_addr_s;
        w_data1_r <= a_data_s;
      end else begin
        w_addr1_r <= w_addr1_r;
        w_data1_r <= w_data1_r;
      end
      if (b_vld_s) begin
        w_addr2_r <= b_addr_s;
        w_data2_r <= b_data_s;
      end else begin
        w_addr2_r <= w_addr2_r;
        w_data2_r <= w_data2_r;
      end
      // pointer moves past the last write-granted requester only
      if (b_vld_s) begin
        rr_ptr_r <= b_idx_s + 2'd1;
      end else if (a_vld_s) begin
        rr_ptr_r <= a_idx_s + 2'd1;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  assign bus.we1     = we1_r;
  assign bus.w_addr1 = w_addr1_r;
  assign bus.w_data1 = w_data1_r;
  assign bus.we2     = we2_r;
  assign bus.w_addr2 = w_addr2_r;
  assign bus.w_data2 = w_data2_r;

`ifdef FP_WB_STALL_STATS_EN
  logic [15:0] stall_r [4];

  // Per-requester stall counters, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        stall_r[i] <= 16'h0000;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (bus.req_valid[i] && !ready_s[i] && !bus.flush &&
            (stall_r[i] != 16'hFFFF)) begin
          stall_r[i] <= stall_r[i] + 16'd1;
        end else begin
          stall_r[i] <= stall_r[i];
        end
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_stall
    assign bus.stall_cnt[g*16 +: 16] = stall_r[g];
  end
`endif

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fp_wb_arbiter
// Directed and random stimulus for fp_wb_arbiter, checked against a
// behavioural reference (scan-order list of requesters, write-port
// expectations and round-robin pointer kept as plain integers).
// -----------------------------------------------------------------------------
module tb_fp_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fp_wb_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  fp_wb_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // reference state
  int            rr_m;
  logic          exp_we1, exp_we2;
  logic [AW-1:0] exp_a1, exp_a2;
  logic [DW-1:0] exp_d1, exp_d2;
  int            stall_m [4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference grant: list requesters in scan order, absorb addr 0, take the
  // first writer and the first later writer aimed at a different register.
  function automatic void ref_grant(input logic [3:0] v, input logic [4*AW-1:0] a,
                                    input int ptr, input logic fl,
                                    output logic [3:0] rdy, output int ia, output int ib);
    int writers[$];
    rdy = 4'b0000;
    ia  = -1;
    ib  = -1;
    if (fl) return;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (ptr + k) % 4;
      if (v[i]) begin
        if (a[i*AW +: AW] == 0) rdy[i] = 1'b1;
        else writers.push_back(i);
      end
    end
    if (writers.size() > 0) begin
      ia = writers[0];
      rdy[ia] = 1'b1;
      for (int j = 1; j < writers.size(); j++) begin
        if (ib < 0 && a[writers[j]*AW +: AW] != a[ia*AW +: AW]) begin
          ib = writers[j];
          rdy[ib] = 1'b1;
        end
      end
    end
  endfunction

  task automatic model_reset();
    rr_m = 0;
    exp_we1 = 1'b0; exp_we2 = 1'b0;
    exp_a1 = '0; exp_a2 = '0; exp_d1 = '0; exp_d2 = '0;
    for (int i = 0; i < 4; i++) stall_m[i] = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_we1"},   {63'd0, bus.we1},   {63'd0, exp_we1});
    check({tag, "_we2"},   {63'd0, bus.we2},   {63'd0, exp_we2});
    check({tag, "_addr1"}, 64'(bus.w_addr1),  64'(exp_a1));
    check({tag, "_addr2"}, 64'(bus.w_addr2),  64'(exp_a2));
    check({tag, "_data1"}, 64'(bus.w_data1),  64'(exp_d1));
    check({tag, "_data2"}, 64'(bus.w_data2),  64'(exp_d2));
  endtask

  // One clock: check req_ready before the edge, outputs after it.
  task automatic cycle(input string tag, output logic [3:0] rdy);
    int ia, ib;
    #1;
    ref_grant(bus.req_valid, bus.req_addr, rr_m, bus.flush, rdy, ia, ib);
    check({tag, "_ready"}, 64'(bus.req_ready), 64'(rdy));
    for (int i = 0; i < 4; i++)
      if (bus.req_valid[i] && !rdy[i] && !bus.flush) stall_m[i]++;
    exp_we1 = (ia >= 0);
    exp_we2 = (ib >= 0);
    if (ia >= 0) begin
      exp_a1 = bus.req_addr[ia*AW +: AW];
      exp_d1 = bus.req_data[ia*DW +: DW];
    end
    if (ib >= 0) begin
      exp_a2 = bus.req_addr[ib*AW +: AW];
      exp_d2 = bus.req_data[ib*DW +: DW];
    end
    if (ib >= 0) rr_m = (ib + 1) % 4;
    else if (ia >= 0) rr_m = (ia + 1) % 4;
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[i]       = v;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  task automatic clear_reqs();
    bus.flush     = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_reqs();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0]    rdy;
  logic          pend  [4];
  logic [AW-1:0] paddr [4];
  logic [DW-1:0] pdata [4];

  initial begin
    // ---- reset with random inputs ----
    rst_n = 1'b0;
    model_reset();
    bus.flush     = 1'($urandom);
    bus.req_valid = 4'($urandom);
    bus.req_addr  = 20'($urandom);
    bus.req_data  = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) @(posedge clk);
    #1;
    check_outputs("rst");
`ifdef FP_WB_STALL_STATS_EN
    check("rst_stall", bus.stall_cnt, 64'd0);
`endif
    @(negedge clk);
    clear_reqs();
    rst_n = 1'b1;
    cycle("idle0", rdy);
    cycle("idle1", rdy);

    // ---- two requests from rr_ptr 0 ----
    set_req(0, 1'b1, 5'd3, 32'h3F80_0000);
    set_req(1, 1'b1, 5'd7, 32'h4000_0000);
    cycle("two", rdy);
    check("two_ready_const", 64'(rdy), 64'(4'b0011));
    check("two_a1_const", 64'(bus.w_addr1), 64'd3);
    check("two_a2_const", 64'(bus.w_addr2), 64'd7);
    clear_reqs();
    cycle("two_idle", rdy);

    // ---- all four distinct: two cycles ----
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, AW'(i + 1), 32'hA000_0000 + 32'(i));
    cycle("four_c1", rdy);
    check("four_c1_const", 64'(rdy), 64'(4'b0011));
    bus.req_valid = bus.req_valid & ~rdy;
    cycle("four_c2", rdy);
    check("four_c2_const", 64'(rdy), 64'(4'b1100));
    clear_reqs();
    cycle("four_idle", rdy);

    // ---- same-address conflict with rr_ptr 1 ----
    do_reset();
    set_req(0, 1'b1, 5'd6, 32'h0000_0066);
    cycle("conf_pre", rdy);
    clear_reqs();
    set_req(1, 1'b1, 5'd5, 32'h1111_1111);
    set_req(2, 1'b1, 5'd5, 32'h2222_2222);
    cycle("conf_c1", rdy);
    check("conf_c1_const", 64'(rdy), 64'(4'b0010));
    check("conf_c1_we2", {63'd0, bus.we2}, 64'd0);
    bus.req_valid = bus.req_valid & ~rdy;
    cycle("conf_c2", rdy);
    check("conf_c2_const", 64'(rdy), 64'(4'b0100));
    check("conf_c2_data", 64'(bus.w_data1), 64'h2222_2222);
    clear_reqs();

    // ---- zero-address absorption ----
    do_reset();
    set_req(0, 1'b1, 5'd0, 32'hDEAD_BEEF);
    set_req(3, 1'b1, 5'd9, 32'h0000_0009);
    cycle("zero", rdy);
    check("zero_const", 64'(rdy), 64'(4'b1001));
    check("zero_a1_const", 64'(bus.w_addr1), 64'd9);
    clear_reqs();
    // rr_ptr should be back at 0: requesters 0 and 1 win over 3
    set_req(0, 1'b1, 5'd1, 32'h1);
    set_req(1, 1'b1, 5'd2, 32'h2);
    set_req(3, 1'b1, 5'd3, 32'h3);
    cycle("zero_rr", rdy);
    check("zero_rr_const", 64'(rdy), 64'(4'b0011));
    clear_reqs();

    // ---- flush ----
    do_reset();
    set_req(0, 1'b1, 5'd10, 32'hF0);
    set_req(1, 1'b1, 5'd11, 32'hF1);
    set_req(2, 1'b1, 5'd12, 32'hF2);
    cycle("pre_flush", rdy);   // grants 0,1; rr -> 2, writes registered
    bus.req_valid = 4'b0000;
    set_req(1, 1'b1, 5'd13, 32'hE1);
    set_req(2, 1'b1, 5'd12, 32'hF2);
    set_req(3, 1'b1, 5'd14, 32'hE3);
    bus.flush = 1'b1;
    cycle("flush", rdy);
    check("flush_const", 64'(bus.req_ready), 64'd0);
    check("flush_we1", {63'd0, bus.we1}, 64'd0);
    bus.flush = 1'b0;
    cycle("post_flush", rdy);  // rr still 2: grants 2,3
    check("post_flush_const", 64'(rdy), 64'(4'b1100));
    clear_reqs();

    // ---- asynchronous reset mid-operation ----
    set_req(0, 1'b1, 5'd4, 32'h4444_4444);
    cycle("mid", rdy);
    clear_reqs();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // ---- random traffic ----
    for (int i = 0; i < 4; i++) pend[i] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom_range(0, 9) < 6)) begin
          pend[i]  = 1'b1;
          paddr[i] = AW'($urandom_range(0, 7));
          pdata[i] = $urandom;
        end
        set_req(i, pend[i], paddr[i], pdata[i]);
      end
      bus.flush = ($urandom_range(0, 9) == 0);
      cycle("rand", rdy);
      for (int i = 0; i < 4; i++) if (rdy[i]) pend[i] = 1'b0;
    end
    clear_reqs();
`ifdef FP_WB_STALL_STATS_EN
    for (int i = 0; i < 4; i++)
      check("rand_stall", 64'(bus.stall_cnt[i*16 +: 16]),
            64'((stall_m[i] > 65535) ? 65535 : stall_m[i]));

    // ---- stall counter saturation ----
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 5'd1, 32'(i));
    for (int n = 0; n < 88000; n++) cycle("sat", rdy);
    for (int i = 0; i < 4; i++)
      check("sat_stall", 64'(bus.stall_cnt[i*16 +: 16]),
            64'((stall_m[i] > 65535) ? 65535 : stall_m[i]));
    check("sat_ffff", 64'(bus.stall_cnt[15:0]), 64'hFFFF);
    clear_reqs();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
